psum_spike_gen: RTL

Clocked accumulate-and-fire stage directly downstream of the PE array. It receives the 13-bit partial sums that the PEs emit, one per output column per filter row. It sums the NUM_ROWS contributions per output column, adds them to a persistent membrane potential, and fires integrate-and-fire spikes against a fixed threshold. Each completed output row is emitted as one DEPTH_O-bit spike vector, which is the ifmap format consumed by the next layer's PEs.

---
 rtl/psum_spike_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/psum_spike_gen.sv
// psum_spike_gen
//
// Accumulate-and-fire stage placed after the PE array. Partial sums arrive
// row-major: filter row is the outer loop and output column is the inner loop.
// For each output column the NUM_ROWS partial sums are added together. That
// sum is then added to a persistent, saturating membrane potential. Each
// neuron fires once against THRESH, and one output row is emitted as a
// DEPTH_O-bit spike vector.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   clr          synchronous clear of membranes, accumulators, counters, spikes
//   psum_valid   psum_data valid          (producer -> block)
//   psum_ready   psum accepted this cycle (block -> producer)
//   psum_data    WIDTH_O-bit unsigned partial sum
//   spike_valid  spike_data valid         (block -> consumer)
//   spike_ready  consumer accepts spike vector
//   spike_data   bit c = spike of output column c
//   busy         high while firing or waiting to send
//   dbg_state    current FSM state (ACCUM=0, FIRE=1, SEND=2)
//
// Handshake (both channels): a transfer happens on a rising edge where valid
// and ready are both high. The sender holds valid and data stable until that
// edge. spike_valid is a pure decode of the registered state, so it never
// depends combinationally on spike_ready.
module psum_spike_gen #(
  parameter int unsigned WIDTH_O  = 13,
  parameter int unsigned DEPTH_O  = 21,
  parameter int unsigned NUM_ROWS = 5,
  parameter int unsigned MEM_W    = 16,
  parameter int unsigned THRESH   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               psum_valid,
  output logic               psum_ready,
  input  logic [WIDTH_O-1:0] psum_data,
  output logic               spike_valid,
  input  logic               spike_ready,
  output logic [DEPTH_O-1:0] spike_data,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int unsigned ACC_W = WIDTH_O + 3;
  localparam int unsigned COL_W = (DEPTH_O > 1) ? $clog2(DEPTH_O) : 1;
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [MEM_W-1:0] THRESH_V = MEM_W'(THRESH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DEPTH_O - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FIRE  = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_fire_idx;
  logic [ACC_W-1:0]   r_acc [DEPTH_O];
  logic [MEM_W-1:0]   r_mem [DEPTH_O];
  logic [DEPTH_O-1:0] r_spike;

  logic               w_xfer;
  logic               w_last_psum;
  logic [MEM_W:0]     w_sum;
  logic [MEM_W-1:0]   w_v;
  logic               w_fire;
  logic [MEM_W-1:0]   w_mem_next;

  assign psum_ready  = (r_state == ACCUM) && !clr;
  assign w_xfer      = psum_valid && psum_ready;
  assign w_last_psum = (r_row == ROW_LAST) && (r_col == COL_LAST);

  assign spike_valid = (r_state == SEND);
  assign spike_data  = r_spike;
  assign busy        = (r_state == FIRE) || (r_state == SEND);
  assign dbg_state   = r_state;

  // Membrane update for the neuron selected by the fire index. The sum is
  // formed one bit wider than the membrane so that the carry-out can select
  // saturation.
  always_comb begin
    w_sum      = {1'b0, r_mem[r_fire_idx]} + (MEM_W+1)'(r_acc[r_fire_idx]);
    w_v        = w_sum[MEM_W] ? {MEM_W{1'b1}} : w_sum[MEM_W-1:0];
    w_fire     = (w_v >= THRESH_V);
    w_mem_next = w_fire ? (w_v - THRESH_V) : w_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clr) begin
      w_next_state = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_xfer && w_last_psum)   w_next_state = FIRE;
        FIRE:    if (r_fire_idx == COL_LAST)  w_next_state = SEND;
        SEND:    if (spike_ready)             w_next_state = ACCUM;
        default:                              w_next_state = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_fire_idx <= '0;
      r_spike    <= '0;
      for (int i = 0; i < int'(DEPTH_O); i++) begin
        r_acc[i] <= '0;
        r_mem[i] <= '0;
      end
    end else if (clr) begin
      r_col      <= '0;
      r_row      <= '0;
      r_fire_idx <= '0;
      r_spike    <= '0;
      for (int i = 0; i < int'(DEPTH_O); i++) begin
        r_acc[i] <= '0;
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_xfer) begin
            // Row 0 overwrites the accumulator, so no separate clear is
            // needed between output rows.
            if (r_row == '0) r_acc[r_col] <= ACC_W'(psum_data);
            else             r_acc[r_col] <= r_acc[r_col] + ACC_W'(psum_data);
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        FIRE: begin
          r_spike[r_fire_idx] <= w_fire;
          r_mem[r_fire_idx]   <= w_mem_next;
          r_fire_idx          <= (r_fire_idx == COL_LAST) ? '0 : r_fire_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
